pio_gpio_irq: RTL and testbench

Parametrised Avalon-MM GPIO port and next-generation successor to the fixed 32-bit output-only PIO register. Provides:
- WIDTH-bit bidirectional port with per-bit direction.
- Atomic bit set/clear of the output register.
- Synchronised inputs with edge capture and a masked interrupt.
Sits on the PCIe-bridged Avalon bus alongside the other PIO peripherals (LEDs, switches, keys).

---
 rtl/pio_gpio_pkg.sv | 39 +++
 rtl/pio_sync_edge.sv | 60 ++++++
 rtl/pio_gpio_irq.sv | 170 +++++++++++++++++
 tb/tb_pio_gpio_irq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pio_gpio_pkg.sv
// -----------------------------------------------------------------------------
// pio_gpio_pkg
//
// Shared definitions for the pio_gpio_irq Avalon-MM GPIO peripheral:
//   - register word addresses (3-bit word select on the Avalon slave)
//   - edge-capture mode encodings used by the EDGE_MODE parameter
//   - a per-bit edge-detect helper shared by the synchroniser block
// -----------------------------------------------------------------------------
package pio_gpio_pkg;

    // Avalon bus data width; the port itself may be narrower.
    localparam int BUS_WIDTH = 32;

    // Register word addresses.
    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    // Edge-capture modes.
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Edge event for one bit, given the current synchronised sample (s)
    // and the sample from the previous cycle (p).
    function automatic logic edge_bit(input int mode, input logic s, input logic p);
        logic hit;
        case (mode)
            EDGE_RISING:  hit = s & ~p;
            EDGE_FALLING: hit = ~s & p;
            default:      hit = s ^ p;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// -----------------------------------------------------------------------------
// pio_sync_edge
//
// Per-bit input synchroniser, previous-sample register and edge detector.
// Asynchronous pin inputs pass through SYNC_STAGES flops; the last stage is
// registered once more (prev) and the pair feeds a combinational edge detect
// selected by EDGE_MODE.
//
// Ports:
//   clk       in   1      clock, rising edge
//   reset_n   in   1      asynchronous active-low reset
//   pin       in   WIDTH  asynchronous pin inputs
//   sync_out  out  WIDTH  synchronised inputs (last synchroniser stage)
//   edge_hit  out  WIDTH  per-bit edge event, valid for one cycle
// -----------------------------------------------------------------------------
module pio_sync_edge
    import pio_gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] edge_hit
);

    // Stage 0 samples the pin; stage SYNC_STAGES-1 is the synchronised value.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]                  prev;

    // Chain and prev both clear in reset so that a low input never looks
    // like an edge when reset is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
            prev  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values; blocking here would collapse
            // the synchroniser into a single stage.
            chain <= {chain[SYNC_STAGES-2:0], pin};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        edge_hit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            edge_hit[i] = edge_bit(EDGE_MODE, sync_out[i], prev[i]);
        end
    end

endmodule

// File: rtl/pio_gpio_irq.sv
// -----------------------------------------------------------------------------
// pio_gpio_irq
//
// Parametrised Avalon-MM GPIO port with per-bit direction, atomic set/clear of
// the output register, synchronised inputs with edge capture and a masked
// level interrupt.
//
// Register map (word address):
//   0 DATA     R: synchronised in_port   W: load data_out
//   1 DIR      R/W, 1 = output
//   2 IRQMASK  R/W
//   3 EDGECAP  R, write-1-to-clear
//   4 OUTSET   W: data_out |= wdata      R: 0
//   5 OUTCLR   W: data_out &= ~wdata     R: 0
//   6,7        reserved, R: 0, W ignored
//
// Ports:
//   clk         in   1      clock, rising edge
//   reset_n     in   1      asynchronous active-low reset
//   address     in   3      register word select
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe
//   read_n      in   1      active-low read strobe
//   writedata   in   32     write data (bits above WIDTH ignored)
//   readdata    out  32     registered read data, read latency 1
//   in_port     in   WIDTH  asynchronous pin inputs
//   out_port    out  WIDTH  output data register
//   oe          out  WIDTH  direction register (1 = drive out_port)
//   irq         out  1      level interrupt, |(edgecap & irqmask)
// -----------------------------------------------------------------------------
module pio_gpio_irq
    import pio_gpio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter int               EDGE_MODE   = EDGE_RISING,
    parameter int               SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic                 read_n,
    input  logic [BUS_WIDTH-1:0] writedata,
    output logic [BUS_WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0]     in_port,
    output logic [WIDTH-1:0]     out_port,
    output logic [WIDTH-1:0]     oe,
    output logic                 irq
);

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;

    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] edge_hit;

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] w1c_bits;
    logic [WIDTH-1:0] edgecap_next;
    logic [WIDTH-1:0] data_out_next;
    logic [BUS_WIDTH-1:0] rd_value;

    // Zero-extend a port-width value to the bus width (works for WIDTH=32).
    function automatic logic [BUS_WIDTH-1:0] widen(input logic [WIDTH-1:0] v);
        logic [BUS_WIDTH-1:0] r;
        r = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // Input synchroniser and edge detect
    // ---------------------------------------------------------------------
    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .pin      (in_port),
        .sync_out (sync_in),
        .edge_hit (edge_hit)
    );

    // ---------------------------------------------------------------------
    // Bus qualifiers
    // ---------------------------------------------------------------------
    assign wr_en = chipselect && !write_n;
    assign rd_en = chipselect && !read_n;
    assign wdata = writedata[WIDTH-1:0];

    // ---------------------------------------------------------------------
    // Next-state logic for the output and edge-capture registers
    // ---------------------------------------------------------------------
    always_comb begin
        data_out_next = data_out;
        w1c_bits      = '0;
        if (wr_en) begin
            case (address)
                ADDR_DATA:    data_out_next = wdata;
                ADDR_OUTSET:  data_out_next = data_out | wdata;
                ADDR_OUTCLR:  data_out_next = data_out & ~wdata;
                ADDR_EDGECAP: w1c_bits      = wdata;
                default:      ;
            endcase
        end
        // Clear first, then set: a new edge in the same cycle as its W1C
        // keeps the bit pending. Output-direction bits never capture.
        edgecap_next = (edgecap & ~w1c_bits) | (edge_hit & ~dir);
    end

    // ---------------------------------------------------------------------
    // Read mux: reflects pre-write register values, so a read and write in
    // the same cycle returns the old contents.
    // ---------------------------------------------------------------------
    always_comb begin
        rd_value = '0;
        case (address)
            ADDR_DATA:    rd_value = widen(sync_in);
            ADDR_DIR:     rd_value = widen(dir);
            ADDR_IRQMASK: rd_value = widen(irqmask);
            ADDR_EDGECAP: rd_value = widen(edgecap);
            default:      rd_value = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_OUT;
            dir      <= RESET_DIR;
            irqmask  <= '0;
            edgecap  <= '0;
            readdata <= '0;
        end else begin
            data_out <= data_out_next;
            edgecap  <= edgecap_next;
            if (wr_en && address == ADDR_DIR) begin
                dir <= wdata;
            end
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= wdata;
            end
            // readdata holds its value until the next qualified read.
            if (rd_en) begin
                readdata <= rd_value;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign out_port = data_out;
    assign oe       = dir;
    // Combinational so that masking drops irq in the same cycle while the
    // captured edges stay pending.
    assign irq      = |(edgecap & irqmask);

endmodule

// File: tb/tb_pio_gpio_irq.sv
// -----------------------------------------------------------------------------
// tb_pio_gpio_irq
//
// Directed self-checking bench for pio_gpio_irq with WIDTH=8, RESET_OUT=8'hA5,
// EDGE_MODE=rising, SYNC_STAGES=2. Inputs change on the falling clock edge and
// outputs are sampled on the falling edge, half a period after the active edge.
// -----------------------------------------------------------------------------
module tb_pio_gpio_irq;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic [2:0]   address;
    logic         chipselect;
    logic         write_n;
    logic         read_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [W-1:0] in_port;
    logic [W-1:0] out_port;
    logic [W-1:0] oe;
    logic         irq;

    int checks   = 0;
    int failures = 0;

    pio_gpio_irq #(
        .WIDTH       (W),
        .RESET_OUT   (8'hA5),
        .RESET_DIR   (8'h00),
        .EDGE_MODE   (0),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe         (oe),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One-cycle write: strobe set at a falling edge, taken at the next rising edge.
    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // One-cycle read; data sampled at the falling edge after the capture edge.
    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        @(negedge clk);
        address    = addr;
        chipselect = 1'b1;
        read_n     = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
        data       = readdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    logic [31:0] rd;

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        read_n     = 1'b1;
        writedata  = 32'h0;
        in_port    = '0;

        // ---------------- reset state ----------------
        #12;
        check("rst_out_port", 32'(out_port), 32'h0000_00A5);
        check("rst_oe",       32'(oe),       32'h0);
        check("rst_irq",      32'(irq),      32'h0);
        check("rst_readdata", readdata,      32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(3'd1, rd);
        check("rst_dir_read", rd, 32'h0);

        // ---------------- output register ops ----------------
        bus_write(3'd0, 32'h0000_000F);
        check("data_write", 32'(out_port), 32'h0F);
        bus_write(3'd4, 32'h0000_0030);
        check("outset", 32'(out_port), 32'h3F);
        bus_write(3'd5, 32'h0000_0003);
        check("outclr", 32'(out_port), 32'h3C);
        bus_read(3'd4, rd);
        check("outset_read0", rd, 32'h0);
        bus_write(3'd0, 32'hFFFF_FF00);
        check("data_wide_write", 32'(out_port), 32'h00);

        // Read DATA returns synchronised inputs, upper bits zero.
        in_port = 8'hFE;
        idle(3);
        bus_read(3'd0, rd);
        check("data_read_sync", rd, 32'h0000_00FE);
        // Clear the rising edges just produced on bits 7..1.
        bus_write(3'd3, 32'hFFFF_FFFF);
        in_port = 8'h00;
        idle(4);

        // Reserved address: write ignored, read zero.
        bus_write(3'd6, 32'h0000_00FF);
        bus_read(3'd6, rd);
        check("reserved_read", rd, 32'h0);

        // Simultaneous read/write of IRQMASK returns the old value.
        @(negedge clk);
        address = 3'd2; writedata = 32'h01; chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
        check("rw_same_cycle_old", readdata, 32'h0);
        bus_read(3'd2, rd);
        check("irqmask_read", rd, 32'h01);

        // ---------------- rising edge timing ----------------
        @(negedge clk);
        in_port[0] = 1'b1;                 // sampled at edge k
        @(negedge clk);
        check("edge_k_irq", 32'(irq), 32'h0);
        @(negedge clk);
        check("edge_k1_irq", 32'(irq), 32'h0);
        @(negedge clk);
        check("edge_k2_irq", 32'(irq), 32'h1);
        bus_read(3'd3, rd);
        check("edgecap_bit0", rd, 32'h01);
        bus_write(3'd3, 32'h01);
        check("w1c_irq_low", 32'(irq), 32'h0);
        in_port[0] = 1'b0;                 // falling edge, not captured
        idle(5);
        bus_read(3'd3, rd);
        check("falling_ignored", rd, 32'h0);

        // ---------------- direction gating ----------------
        bus_write(3'd1, 32'h01);
        check("oe_dir", 32'(oe), 32'h01);
        in_port[0] = 1'b1;
        idle(5);
        in_port[0] = 1'b0;
        idle(5);
        bus_read(3'd3, rd);
        check("dir_out_gated", rd, 32'h0);
        bus_write(3'd1, 32'h00);
        in_port[0] = 1'b1;
        idle(5);
        bus_read(3'd3, rd);
        check("dir_in_capture", rd, 32'h01);

        // ---------------- W1C vs new edge race ----------------
        bus_write(3'd3, 32'h01);
        in_port[0] = 1'b0;
        idle(5);
        @(negedge clk);
        in_port[0] = 1'b1;                 // edge k
        @(negedge clk);                    // after k
        @(negedge clk);                    // after k+1: W1C lands on edge k+2
        address = 3'd3; writedata = 32'h01; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        check("race_irq", 32'(irq), 32'h1);
        bus_read(3'd3, rd);
        check("race_set_wins", rd, 32'h01);
        bus_write(3'd3, 32'h01);
        check("race_later_clear_irq", 32'(irq), 32'h0);
        bus_read(3'd3, rd);
        check("race_later_clear", rd, 32'h0);

        // ---------------- mask and reset ----------------
        bus_write(3'd2, 32'h00);
        in_port[3] = 1'b1;
        idle(5);
        check("masked_irq", 32'(irq), 32'h0);
        bus_read(3'd3, rd);
        check("masked_edgecap", rd, 32'h08);
        bus_write(3'd2, 32'h08);
        check("unmask_irq", 32'(irq), 32'h1);
        bus_write(3'd2, 32'h00);
        check("remask_irq", 32'(irq), 32'h0);
        bus_write(3'd2, 32'h08);
        check("reunmask_irq", 32'(irq), 32'h1);

        // Asynchronous reset mid-frame.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_irq",      32'(irq),      32'h0);
        check("async_rst_out_port", 32'(out_port), 32'h0000_00A5);
        check("async_rst_readdata", readdata,      32'h0);
        // Release with in_port = 0x09 held high; re-enable mask in the same cycle.
        @(negedge clk);
        reset_n    = 1'b1;
        address    = 3'd2; writedata = 32'h09; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);                    // after r0
        chipselect = 1'b0; write_n = 1'b1;
        check("post_rst_r0_irq", 32'(irq), 32'h0);
        @(negedge clk);                    // after r1
        check("post_rst_r1_irq", 32'(irq), 32'h0);
        @(negedge clk);                    // after r2: inputs really rose from reset 0
        check("post_rst_r2_irq", 32'(irq), 32'h1);
        bus_read(3'd3, rd);
        check("post_rst_edgecap", rd, 32'h09);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
